// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance controller: operation codes,
// controller FSM states, CSR field positions and the ELO packing helper.
// Ports: none (package).
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

    // TLBIDX fields
    localparam int TLBIDX_NE    = 31;
    localparam int TLBIDX_PS_HI = 29;
    localparam int TLBIDX_PS_LO = 24;

    // TLBEHI fields
    localparam int EHI_VPPN_HI = 31;
    localparam int EHI_VPPN_LO = 13;

    // TLBELO0/1 fields
    localparam int ELO_V      = 0;
    localparam int ELO_D      = 1;
    localparam int ELO_PLV_LO = 2;
    localparam int ELO_PLV_HI = 3;
    localparam int ELO_MAT_LO = 4;
    localparam int ELO_MAT_HI = 5;
    localparam int ELO_G      = 6;
    localparam int ELO_PPN_LO = 8;
    localparam int ELO_PPN_HI = 27;

    // Largest INVTLB op value that is architecturally defined.
    localparam logic [4:0] INVTLB_MAX_OP = 5'd6;

    // Build a TLBELO register image; bit 7 and bits 31:28 read as zero.
    function automatic logic [31:0] pack_elo(
        input logic [19:0] ppn,
        input logic        g,
        input logic [1:0]  mat,
        input logic [1:0]  plv,
        input logic        d,
        input logic        v
    );
        return {4'd0, ppn, 1'b0, g, mat, plv, d, v};
    endfunction

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running fill index counter for TLBFILL. Counts every cycle and wraps
// from TLBNUM-1 to 0; the value present in the cycle of a capture request is
// held on cap_index until the next capture.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   capture      - latch the current count (instruction handshake)
//   cap_index    - count value latched at the last capture
module tlb_fill_ctr
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            capture,
    output logic [IDXW-1:0] cap_index
);

    logic [IDXW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            cap_index <= '0;
        end else begin
            count <= (count == IDXW'(TLBNUM - 1)) ? '0 : count + 1'b1;
            if (capture) begin
                cap_index <= count;
            end
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance controller: executes TLBSRCH, TLBRD, TLBWR, TLBFILL and
// INVTLB over three cycles (IDLE -> EXEC -> DONE) and returns CSR write-back
// data to the pipeline.
// Ports:
//   clk, resetn               - clock, asynchronous active-low reset
//   op_valid/op_ready/op_code - instruction handshake from EX
//   inv_op/inv_asid/inv_va    - INVTLB operands
//   csr_*                     - current TLBIDX/TLBEHI/TLBELO0/1/ASID values
//   tlb_s1_*                  - search port 1 request/result (owned while tlb_s1_own)
//   tlb_invtlb_*              - invalidate strobe
//   tlb_we, tlb_w_*           - array write port
//   tlb_r_index, tlb_r_*      - array read port
//   done_valid/done_exc       - completion pulse and INE exception flag
//   csr_we_*, *_wdata         - CSR write-back, valid with done_valid
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    localparam int IDXW = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [31:0]     inv_va,
    input  logic [31:0]     csr_tlbidx,
    input  logic [31:0]     csr_tlbehi,
    input  logic [31:0]     csr_tlbelo0,
    input  logic [31:0]     csr_tlbelo1,
    input  logic [9:0]      csr_asid,
    output logic            tlb_s1_own,
    output logic [18:0]     tlb_s1_vppn,
    output logic            tlb_s1_va_bit12,
    output logic [9:0]      tlb_s1_asid,
    input  logic            tlb_s1_found,
    input  logic [IDXW-1:0] tlb_s1_index,
    output logic            tlb_invtlb_valid,
    output logic [4:0]      tlb_invtlb_op,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_w_e,
    output logic [5:0]      tlb_w_ps,
    output logic [18:0]     tlb_w_vppn,
    output logic [9:0]      tlb_w_asid,
    output logic            tlb_w_g,
    output logic [19:0]     tlb_w_ppn0,
    output logic [1:0]      tlb_w_plv0,
    output logic [1:0]      tlb_w_mat0,
    output logic            tlb_w_d0,
    output logic            tlb_w_v0,
    output logic [19:0]     tlb_w_ppn1,
    output logic [1:0]      tlb_w_plv1,
    output logic [1:0]      tlb_w_mat1,
    output logic            tlb_w_d1,
    output logic            tlb_w_v1,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic            tlb_r_e,
    input  logic [18:0]     tlb_r_vppn,
    input  logic [5:0]      tlb_r_ps,
    input  logic [9:0]      tlb_r_asid,
    input  logic            tlb_r_g,
    input  logic [19:0]     tlb_r_ppn0,
    input  logic [1:0]      tlb_r_plv0,
    input  logic [1:0]      tlb_r_mat0,
    input  logic            tlb_r_d0,
    input  logic            tlb_r_v0,
    input  logic [19:0]     tlb_r_ppn1,
    input  logic [1:0]      tlb_r_plv1,
    input  logic [1:0]      tlb_r_mat1,
    input  logic            tlb_r_d1,
    input  logic            tlb_r_v1,
    output logic            done_valid,
    output logic            done_exc,
    output logic            csr_we_tlbidx,
    output logic            csr_we_tlbehi,
    output logic            csr_we_elo0,
    output logic            csr_we_elo1,
    output logic            csr_we_asid,
    output logic [31:0]     tlbidx_wdata,
    output logic [31:0]     tlbehi_wdata,
    output logic [31:0]     elo0_wdata,
    output logic [31:0]     elo1_wdata,
    output logic [9:0]      asid_wdata
);

    ctrl_state_e     state;
    logic            handshake;
    logic            exc_in;
    logic            exc_q;
    logic [IDXW-1:0] fill_index;

    // Operands captured at handshake; they only feed outputs that are
    // qualified by a strobe, so they carry no reset.
    logic [2:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [31:0]     inv_va_q;
    logic [31:0]     tlbidx_q;
    logic [31:0]     ehi_q;
    logic [31:0]     elo0_q;
    logic [31:0]     elo1_q;
    logic [9:0]      asid_q;

    // Register bits with no meaning for this controller.
    logic            unused_bits;

    assign handshake = op_valid & op_ready;

    // Reserved op codes and undefined INVTLB ops raise INE instead of acting.
    assign exc_in = (op_code > OP_INV) |
                    ((op_code == OP_INV) & (inv_op > INVTLB_MAX_OP));

    tlb_fill_ctr #(.TLBNUM(TLBNUM)) u_fill_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .capture   (handshake),
        .cap_index (fill_index)
    );

    always_ff @(posedge clk) begin
        if (handshake) begin
            op_q       <= op_code;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_va_q   <= inv_va;
            tlbidx_q   <= csr_tlbidx;
            ehi_q      <= csr_tlbehi;
            elo0_q     <= csr_tlbelo0;
            elo1_q     <= csr_tlbelo1;
            asid_q     <= csr_asid;
        end
    end

    // Search port 1: TLBSRCH looks up EHI/ASID, INVTLB looks up its operands.
    assign tlb_s1_vppn     = (op_q == OP_INV) ? inv_va_q[31:13] : ehi_q[EHI_VPPN_HI:EHI_VPPN_LO];
    assign tlb_s1_asid     = (op_q == OP_INV) ? inv_asid_q : asid_q;
    assign tlb_s1_va_bit12 = (op_q == OP_INV) ? inv_va_q[12] : 1'b0;
    assign tlb_invtlb_op   = inv_op_q;

    assign tlb_r_index = tlbidx_q[IDXW-1:0];

    assign tlb_w_index = (op_q == OP_FILL) ? fill_index : tlbidx_q[IDXW-1:0];
    assign tlb_w_e     = ~tlbidx_q[TLBIDX_NE];
    assign tlb_w_ps    = tlbidx_q[TLBIDX_PS_HI:TLBIDX_PS_LO];
    assign tlb_w_vppn  = ehi_q[EHI_VPPN_HI:EHI_VPPN_LO];
    assign tlb_w_asid  = asid_q;
    assign tlb_w_g     = elo0_q[ELO_G] & elo1_q[ELO_G];
    assign tlb_w_ppn0  = elo0_q[ELO_PPN_HI:ELO_PPN_LO];
    assign tlb_w_plv0  = elo0_q[ELO_PLV_HI:ELO_PLV_LO];
    assign tlb_w_mat0  = elo0_q[ELO_MAT_HI:ELO_MAT_LO];
    assign tlb_w_d0    = elo0_q[ELO_D];
    assign tlb_w_v0    = elo0_q[ELO_V];
    assign tlb_w_ppn1  = elo1_q[ELO_PPN_HI:ELO_PPN_LO];
    assign tlb_w_plv1  = elo1_q[ELO_PLV_HI:ELO_PLV_LO];
    assign tlb_w_mat1  = elo1_q[ELO_MAT_HI:ELO_MAT_LO];
    assign tlb_w_d1    = elo1_q[ELO_D];
    assign tlb_w_v1    = elo1_q[ELO_V];

    assign unused_bits = ^{ehi_q[EHI_VPPN_LO-1:0], inv_va_q[11:0],
                           elo0_q[31:28], elo0_q[7], elo1_q[31:28], elo1_q[7]};

    // Controller FSM. Strobes are registered so they are high exactly for the
    // EXEC cycle; the async reset clears them immediately on abort.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= ST_IDLE;
            op_ready         <= 1'b1;
            exc_q            <= 1'b0;
            tlb_s1_own       <= 1'b0;
            tlb_invtlb_valid <= 1'b0;
            tlb_we           <= 1'b0;
            done_valid       <= 1'b0;
            done_exc         <= 1'b0;
            csr_we_tlbidx    <= 1'b0;
            csr_we_tlbehi    <= 1'b0;
            csr_we_elo0      <= 1'b0;
            csr_we_elo1      <= 1'b0;
            csr_we_asid      <= 1'b0;
            tlbidx_wdata     <= '0;
            tlbehi_wdata     <= '0;
            elo0_wdata       <= '0;
            elo1_wdata       <= '0;
            asid_wdata       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        state            <= ST_EXEC;
                        op_ready         <= 1'b0;
                        exc_q            <= exc_in;
                        tlb_s1_own       <= (op_code == OP_SRCH) | (op_code == OP_INV);
                        tlb_invtlb_valid <= (op_code == OP_INV) & ~exc_in;
                        tlb_we           <= (op_code == OP_WR) | (op_code == OP_FILL);
                    end
                end

                ST_EXEC: begin
                    state            <= ST_DONE;
                    tlb_s1_own       <= 1'b0;
                    tlb_invtlb_valid <= 1'b0;
                    tlb_we           <= 1'b0;
                    done_valid       <= 1'b1;
                    done_exc         <= exc_q;
                    if (op_q == OP_SRCH) begin
                        csr_we_tlbidx <= 1'b1;
                        // Miss keeps the old index and only sets NE.
                        tlbidx_wdata  <= tlb_s1_found ?
                                         {1'b0, tlbidx_q[30:IDXW], tlb_s1_index} :
                                         {1'b1, tlbidx_q[30:0]};
                    end else if (op_q == OP_RD) begin
                        csr_we_tlbidx <= 1'b1;
                        csr_we_tlbehi <= 1'b1;
                        csr_we_elo0   <= 1'b1;
                        csr_we_elo1   <= 1'b1;
                        csr_we_asid   <= 1'b1;
                        tlbidx_wdata  <= {~tlb_r_e, tlbidx_q[30],
                                          (tlb_r_e ? tlb_r_ps : 6'd0), tlbidx_q[23:0]};
                        tlbehi_wdata  <= tlb_r_e ? {tlb_r_vppn, 13'd0} : 32'd0;
                        elo0_wdata    <= tlb_r_e ? pack_elo(tlb_r_ppn0, tlb_r_g, tlb_r_mat0,
                                                            tlb_r_plv0, tlb_r_d0, tlb_r_v0) : 32'd0;
                        elo1_wdata    <= tlb_r_e ? pack_elo(tlb_r_ppn1, tlb_r_g, tlb_r_mat1,
                                                            tlb_r_plv1, tlb_r_d1, tlb_r_v1) : 32'd0;
                        asid_wdata    <= tlb_r_e ? tlb_r_asid : 10'd0;
                    end
                end

                ST_DONE: begin
                    state         <= ST_IDLE;
                    op_ready      <= 1'b1;
                    done_valid    <= 1'b0;
                    done_exc      <= 1'b0;
                    csr_we_tlbidx <= 1'b0;
                    csr_we_tlbehi <= 1'b0;
                    csr_we_elo0   <= 1'b0;
                    csr_we_elo1   <= 1'b0;
                    csr_we_asid   <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle controller that executes the TLB-maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB on behalf of the EX stage. It sits directly upstream of the `tlb` array. It drives the array's write port, read port, invtlb strobe and search port 1. It returns CSR write-back data for TLBIDX, TLBEHI, TLBELO0/1 and ASID. A valid/ready handshake stalls the pipeline until the instruction completes.

## Interface
- `TLBNUM`, 16, number of TLB entries; `IDXW = $clog2(TLBNUM)` is a derived localparam.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  EX presents a TLB instruction.
- `op_ready`  out  1  controller idle; transfer on `op_valid & op_ready`.
- `op_code`  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5–7 are reserved.
- `inv_op`  in  5  INVTLB op field.
- `inv_asid`  in  10  rj[9:0] for INVTLB.
- `inv_va`  in  32  rk for INVTLB.
- `csr_tlbidx`  in  32  fields: [IDXW-1:0] index, [29:24] ps, [31] ne.
- `csr_tlbehi`  in  32  field: [31:13] vppn.
- `csr_tlbelo0`, `csr_tlbelo1`  in  32  fields: [0] v, [1] d, [3:2] plv, [5:4] mat, [6] g, [27:8] ppn.
- `csr_asid`  in  10  ASID.ASID.
- `tlb_s1_own`  out  1  when 1, top level routes `tlb_s1_*` to search port 1; otherwise the MEM stage owns the port.
- `tlb_s1_vppn` (out, 19), `tlb_s1_va_bit12` (out, 1), `tlb_s1_asid` (out, 10)  search request.
- `tlb_s1_found` (in, 1), `tlb_s1_index` (in, IDXW)  search result.
- `tlb_invtlb_valid` (out, 1), `tlb_invtlb_op` (out, 5)  invalidate strobe.
- `tlb_we` (out, 1), `tlb_w_index` (out, IDXW)  write strobe and target entry.
- `tlb_w_e`, `tlb_w_ps`, `tlb_w_vppn`, `tlb_w_asid`, `tlb_w_g`, `tlb_w_{ppn,plv,mat,d,v}{0,1}`  out  widths as the `tlb` write port.
- `tlb_r_index` (out, IDXW)  read address.
- `tlb_r_*` (in)  widths as the `tlb` read port.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_exc`  out  1  with `done_valid`; 1 means an INE exception (reserved op or `inv_op` > 6).
- `csr_we_tlbidx`, `csr_we_tlbehi`, `csr_we_elo0`, `csr_we_elo1`, `csr_we_asid`  out  1  write enables, valid only during `done_valid`.
- `tlbidx_wdata`, `tlbehi_wdata`, `elo0_wdata`, `elo1_wdata`  out  32  CSR write-back values.
- `asid_wdata`  out  10  ASID write-back value.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE → EXEC on handshake; `op_code`, `inv_*`, all CSR inputs and the fill index are captured.
  - EXEC → DONE always.
  - DONE → IDLE always.
- `op_ready` = (state==IDLE).
- `tlb_s1_own` = (state==EXEC & op ∈ {SRCH, INV}).
- **Fill index counter:** IDXW-bit, increments every cycle, wraps TLBNUM-1→0. TLBFILL uses the counter value captured at handshake.
- **SRCH:** `s1_vppn` = ehi.vppn, `s1_asid` = csr_asid, `va_bit12` = 0.
  - Hit: tlbidx index ← `s1_index`, ne ← 0.
  - Miss: ne ← 1, index unchanged.
  - Only `csr_we_tlbidx` is asserted. Other tlbidx bits pass through.
- **RD:** `r_index` = tlbidx.index; results are registered in EXEC.
  - `r_e=1`: ne ← 0, ps ← `r_ps`, ehi.vppn ← `r_vppn`, elo0/elo1 fields ← `r_*`, both elo g bits ← `r_g`, asid ← `r_asid`.
  - `r_e=0`: ne ← 1, ps ← 0, ehi/elo0/elo1/asid ← 0.
  - All five CSR write enables are asserted.
- **WR/FILL:**
  - `tlb_we` is high for the EXEC cycle only.
  - Index: tlbidx.index for WR, captured counter for FILL.
  - Field mapping: `w_e` = ~ne, `w_ps` = tlbidx.ps, `w_vppn` = ehi.vppn, `w_asid` = csr_asid, `w_g` = elo0.g & elo1.g; elo fields map to the 0/1 sets.
  - No CSR write.
- **INV:** `tlb_invtlb_valid` is high for the EXEC cycle with `inv_op`; `s1_asid` = inv_asid, `s1_vppn` = inv_va[31:13].
  - `inv_op` > 6 or `op_code` ≥ 5: no TLB strobe; DONE asserts `done_exc`.
- **Outputs in non-EXEC states:** all strobes are 0. `w_*`/`s1_*` are don't-care while their strobe or `own` is low.

## Timing
- Handshake at edge T. EXEC spans T→T+1: strobes are high and the array updates at edge T+1.
- DONE spans T+1→T+2: `done_valid` and CSR data are registered.
- `op_ready` is high again from T+2. Minimum issue interval is 3 cycles.
- `op_valid` while `op_ready`=0 is ignored; EX must hold it.
- Reset values:
  - state=IDLE, so `op_ready`=1.
  - Counter=0.
  - All strobes, write enables, `done_valid`, `done_exc` = 0.
  - Write-back data = 0.
- Reset asserted mid-operation aborts immediately: no further strobe, no `done_valid`.
- A TLBRD immediately after a TLBWR to the same index reads the new entry, because the write completes before the next EXEC.

## Structure
- Shared package `tlb_pkg` holds:
  - op-code enum, FSM state enum;
  - CSR field offsets (TLBIDX_NE=31, PS=29:24, EHI_VPPN=31:13, ELO_* bits);
  - the INVTLB max-op constant 6.
- Sub-module `tlb_fill_ctr` is the wrapping fill index counter with a capture output.

## Test plan
- Reset, then TLBWR with index=3, ps=12, vppn=0x12345, asid=5, elo0.v=1, ppn0=0xABCDE. Required: `tlb_we` high for 1 cycle at index 3; `done_valid` 2 cycles after handshake; `op_ready` returns 1 cycle later.
- TLBSRCH for vppn 0x12345, asid 5 after that write. Required: tlbidx_wdata index=3, ne=0. With asid 6 and g=0: ne=1, index unchanged.
- TLBRD index 3: ehi=0x2468A000 (vppn 0x12345), elo0 ppn=0xABCDE, v=1, asid_wdata=5. TLBRD of an empty entry: ne=1, ps=0, elo0=elo1=0.
- TLBFILL issued 21 cycles after reset deassertion: `w_index`=21 mod 16 = 5. Repeat across wrap 15→0.
- INVTLB op=5 with asid=5 and va=0x2468A000: `invtlb_valid` high 1 cycle, op=5. op=7: no strobe, `done_exc`=1.
- Assert `resetn` during EXEC of a TLBWR: `tlb_we` drops at once, no `done_valid`, `op_ready`=1, counter=0.
